// File: rtl/filter_storage.sv
// Filter sample/coefficient store: 512 x 16 flop array, one write port, one registered read port.
// Optional FILTER_STORAGE_WR_BYPASS_EN forwards same-cycle write data to a read of the same address.
module filter_storage #(
   parameter  int DATA_W = 16,
   parameter  int ADDR_W = 9,
   localparam int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              wren,
   input  logic [ADDR_W-1:0] wrptr,
   input  logic [DATA_W-1:0] wrdata,
   input  logic              rden,
   input  logic [ADDR_W-1:0] rdptr,
   output logic [DATA_W-1:0] rddata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_word;

   // Word presented to the read register; mem holds pre-write contents this cycle.
   always_comb begin
      rd_word = mem[rdptr];
`ifdef FILTER_STORAGE_WR_BYPASS_EN
      if (wren && (wrptr == rdptr)) begin
         rd_word = wrdata;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rddata <= '0;
      end else begin
         if (wren) begin
            mem[wrptr] <= wrdata;
         end
         if (rden) begin
            rddata <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_filter_storage.sv
// Directed self-checking bench for filter_storage; expected values are hand-computed constants.
// Collision expectation follows FILTER_STORAGE_WR_BYPASS_EN when that macro is defined.
module tb_filter_storage;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 9;

   logic              clk;
   logic              rstb;
   logic              wren;
   logic [ADDR_W-1:0] wrptr;
   logic [DATA_W-1:0] wrdata;
   logic              rden;
   logic [ADDR_W-1:0] rdptr;
   logic [DATA_W-1:0] rddata;

   int n_vec = 0;
   int n_err = 0;

   filter_storage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk    (clk),
      .rstb   (rstb),
      .wren   (wren),
      .wrptr  (wrptr),
      .wrdata (wrdata),
      .rden   (rden),
      .rdptr  (rdptr),
      .rddata (rddata)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: rddata=%h expected=%h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wren = 1'b1; wrptr = a; wrdata = d;
      tick();
      wren = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] exp);
      rden = 1'b1; rdptr = a;
      tick();
      rden = 1'b0;
      check(tag, rddata, exp);
   endtask

   logic [ADDR_W:0] wide_ptr;

   initial begin
      rstb = 1'b0; wren = 1'b0; wrptr = '0; wrdata = '0; rden = 1'b0; rdptr = '0;

      // reset held 10 cycles with enables toggling, then release
      repeat (10) begin
         wren = 1'b1; rden = 1'b1; wrdata = 16'hFFFF;
         tick();
      end
      wren = 1'b0; rden = 1'b0;
      check("rst_hold", rddata, 16'h0000);
      rstb = 1'b1;
      do_read("rst_rd0", 9'd0, 16'h0000);
      do_read("rst_rd1", 9'd1, 16'h0000);
      do_read("rst_rd511", 9'd511, 16'h0000);

      // basic write / back-to-back read
      do_write(9'd0, 16'hAAAA);
      do_write(9'd1, 16'hBBBB);
      rden = 1'b1; rdptr = 9'd1;
      tick();
      check("basic_rd1", rddata, 16'hBBBB);
      rdptr = 9'd0;
      tick();
      check("basic_rd0", rddata, 16'hAAAA);
      rden = 1'b0;

      // hold while rden=0, rdptr changed
      do_read("hold_pre", 9'd1, 16'hBBBB);
      rdptr = 9'd0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold", rddata, 16'hBBBB);
      end

      // wren=0 must not write
      wren = 1'b0; wrptr = 9'd1; wrdata = 16'hDEAD;
      tick();
      do_read("nowr_rd1", 9'd1, 16'hBBBB);

      // boundary and wrapped pointer (512 arrives as 0)
      do_write(9'd511, 16'h1234);
      wide_ptr = 10'd512;
      do_write(wide_ptr[ADDR_W-1:0], 16'h5678);
      do_read("wrap_rd511", 9'd511, 16'h1234);
      do_read("wrap_rd0", 9'd0, 16'h5678);
      do_read("wrap_rd1", 9'd1, 16'hBBBB);
      do_read("wrap_rd2", 9'd2, 16'h0000);
      do_read("wrap_rd510", 9'd510, 16'h0000);

      // same-address collision
      do_write(9'd5, 16'h1111);
      wren = 1'b1; wrptr = 9'd5; wrdata = 16'h2222;
      rden = 1'b1; rdptr = 9'd5;
      tick();
      wren = 1'b0; rden = 1'b0;
`ifdef FILTER_STORAGE_WR_BYPASS_EN
      check("coll_same", rddata, 16'h2222);
`else
      check("coll_same", rddata, 16'h1111);
`endif
      do_read("coll_after", 9'd5, 16'h2222);

      // simultaneous read and write, different addresses
      wren = 1'b1; wrptr = 9'd6; wrdata = 16'h3333;
      rden = 1'b1; rdptr = 9'd1;
      tick();
      wren = 1'b0; rden = 1'b0;
      check("diff_rd1", rddata, 16'hBBBB);
      do_read("diff_rd6", 9'd6, 16'h3333);

      // reset mid-operation
      do_write(9'd7, 16'hBEEF);
      do_read("mid_pre", 9'd7, 16'hBEEF);
      rstb = 1'b0;
      wren = 1'b1; wrptr = 9'd7; wrdata = 16'hCAFE;
      rden = 1'b1; rdptr = 9'd7;
      tick();
      check("mid_rst", rddata, 16'h0000);
      rstb = 1'b1; wren = 1'b0; rden = 1'b0;
      do_read("mid_rd7", 9'd7, 16'h0000);
      do_read("mid_rd1", 9'd1, 16'h0000);
      do_read("mid_rd511", 9'd511, 16'h0000);

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/filter_storage.md
Name: filter_storage

Overview:
- Simple dual-port storage array (one write port, one read port) holding filter samples/coefficients for the filter datapath.
- 512 words x 16 bits, one clock domain.
- Registered read data with 1-cycle latency.
- Storage is flop-based so that reset can clear the contents deterministically.

Parameters:
- DATA_W, 16, width of each stored word and of wrdata/rddata.
- ADDR_W, 9, pointer width.
- DEPTH, 2**ADDR_W (512), number of words; the full pointer range is always valid.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rstb  input  1  reset, synchronous and active-low; sampled on the clk rising edge.
- wren  input  1  write enable.
- wrptr  input  ADDR_W  write address.
- wrdata  input  DATA_W  write data.
- rden  input  1  read enable.
- rdptr  input  ADDR_W  read address.
- rddata  output  DATA_W  registered read data.

Behaviour:
- Reset (rstb=0 at a clk edge):
  - rddata <= 0.
  - All DEPTH words are cleared to 0.
  - wren and rden are ignored during that cycle.
- Write: at a clk edge with rstb=1 and wren=1, mem[wrptr] <= wrdata.
  - Writes take effect at that edge only.
  - No write occurs when wren=0.
- Read: at a clk edge with rstb=1 and rden=1, rddata <= mem[rdptr].
  - Data is valid after the edge (latency 1 cycle from rden/rdptr sampling).
- rden=0: rddata holds its previous value. There is no combinational path from rdptr to rddata.
- Addressing:
  - Pointers are plain ADDR_W-bit indices; there is no out-of-range case.
  - Upstream pointer arithmetic wraps modulo DEPTH before reaching the block (e.g. 0 + 513 arrives as 1).
- Width: wrdata is stored exactly as DATA_W bits, with no sign or width conversion.
- Simultaneous read and write to different addresses: fully independent, both complete in the same cycle.
- Simultaneous read and write to the same address: behaviour is set by the optional feature below. The default is read-before-write: rddata gets the old contents.
- Reset mid-operation: reset wins over any concurrent wren/rden. The contents are lost and rddata returns to 0.
- No status outputs and no handshake; the caller is responsible for pointer management.

Optional Feature:
- Macro: FILTER_STORAGE_WR_BYPASS_EN.
- Defined: on a same-cycle wren=1, rden=1, wrptr==rdptr, rddata <= wrdata (write-first forwarding). The stored word is also updated.
- Undefined: same case gives rddata <= the previous mem[rdptr] (read-before-write). The new value is visible on the next read.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: hold rstb=0 for 10 cycles, release, then read addresses 0, 1, 511 -> rddata=0x0000 each, one cycle after the rden edge.
- Basic write/read:
  - Stimulus: write 0xAAAA @0, write 0xBBBB @1, then rden=1 with rdptr=1, then rdptr=0.
  - Response: rddata=0xBBBB one cycle after the first read, then 0xAAAA.
- Wrap and boundary: write 0x1234 @511 and 0x5678 @0 (0 driven as a wrapped 512), read both -> 0x1234 and 0x5678; no other address changes.
- Hold and disable:
  - Stimulus: after reading 0xBBBB, drop rden and change rdptr to 0 for 5 cycles.
  - Response: rddata stays 0xBBBB.
  - Also: a write with wren=0 leaves the target word unchanged.
- Same-address collision:
  - Stimulus: mem[5]=0x1111, then in one cycle write 0x2222 @5 with rden=1, rdptr=5.
  - Response without macro: rddata=0x1111, next read gives 0x2222.
  - Response with FILTER_STORAGE_WR_BYPASS_EN: rddata=0x2222.
- Reset mid-operation:
  - Stimulus: write 0xBEEF @7, assert rstb=0 for 1 cycle while wren=1 and rden=1, then read @7.
  - Response: rddata=0 during reset and 0x0000 on the read; the write issued during the reset cycle is discarded.
